// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register slice.
// SKID_EN=1 gives a two-entry skid buffer whose in_ready is a flop, which cuts
// the combinational out_ready -> in_ready path. SKID_EN=0 gives a single entry
// with combinational in_ready. A saturating counter records back-pressure.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_EMPTY | no payload held, out_valid=0
// ST_ONE   | main entry valid, skid entry empty
// ST_FULL  | main and skid entries valid, in_ready=0 (SKID_EN=1 only)
//
// Bit 0 of the encoding is the main valid flag and bit 1 is the skid valid
// flag, so out_valid is read straight off a flop.
module pipe_stage_reg #(
    parameter int DATA_W  = 64,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] main_data_nxt;
    logic [DATA_W-1:0] skid_data;
    logic [DATA_W-1:0] skid_data_nxt;
    logic [1:0]        occ_r;
    logic [1:0]        occ_nxt;
    logic [CNT_W-1:0]  stall_r;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = state[0];
    assign out_data  = main_data;
    assign occupancy = occ_r;
    assign stall_cnt = stall_r;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Occupancy is kept as its own flop so the output is glitch-free.
    assign occ_nxt = {1'b0, state_nxt[0]} + {1'b0, state_nxt[1]};

    // Next-state and next-data selection for both buffer depths.
    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        skid_data_nxt = skid_data;
        if (SKID_EN != 0) begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nxt     = ST_ONE;
                        main_data_nxt = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_nxt = in_data;
                    end else if (in_fire) begin
                        state_nxt     = ST_FULL;
                        skid_data_nxt = in_data;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_nxt     = ST_ONE;
                        main_data_nxt = skid_data;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end else begin
            if (in_fire) begin
                state_nxt     = ST_ONE;
                main_data_nxt = in_data;
            end else if (out_fire) begin
                state_nxt = ST_EMPTY;
            end
        end
    end

    // Entry registers; reset and flush both wipe valid flags and payloads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            skid_data <= '0;
            occ_r     <= 2'd0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            skid_data <= '0;
            occ_r     <= 2'd0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            skid_data <= skid_data_nxt;
            occ_r     <= occ_nxt;
        end
    end

    // Back-pressure counter; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r <= '0;
        end else if (clr_cnt) begin
            stall_r <= '0;
        end else if (out_valid && !out_ready && (stall_r != CNT_MAX)) begin
            stall_r <= stall_r + CNT_W'(1);
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            logic in_ready_r;

            // in_ready tracks "skid entry free" one cycle ahead, from a flop.
            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready_r <= 1'b1;
                end else if (flush) begin
                    in_ready_r <= 1'b1;
                end else begin
                    in_ready_r <= ~state_nxt[1];
                end
            end

            assign in_ready = in_ready_r;
        end else begin : g_single
            assign in_ready = ~state[0] | out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=2) and a single-entry
// instance (CNT_W=3) share one stimulus stream. Accepted payloads go into a
// per-instance scoreboard queue; a negedge monitor pops on each output transfer.
module tb_pipe_stage_reg;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic          clr_cnt;
    logic [DW-1:0] in_data;

    logic [1:0]    in_ready;
    logic [1:0]    out_valid;
    logic [DW-1:0] out_data [2];
    logic [1:0]    occupancy [2];
    logic [1:0]    stall0;
    logic [2:0]    stall1;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1), .CNT_W(2)) dut_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .occupancy(occupancy[0]), .clr_cnt(clr_cnt), .stall_cnt(stall0)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID_EN(0), .CNT_W(3)) dut_single (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .occupancy(occupancy[1]), .clr_cnt(clr_cnt), .stall_cnt(stall1)
    );

    int            checks = 0;
    int            errors = 0;
    bit            chk_en = 0;

    logic [DW-1:0] sb0 [$];
    logic [DW-1:0] sb1 [$];
    int            m_occ   [2];
    int            m_stall [2];
    logic [DW-1:0] m_last  [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model view of readiness: skid version has room for two and decides a
    // cycle ahead; single version frees its slot in the same cycle it drains.
    function automatic bit m_ready(input int k);
        if (k == 0) return m_occ[0] < 2;
        return (m_occ[1] == 0) || (out_ready == 1'b1);
    endfunction

    function automatic int m_smax(input int k);
        return (k == 0) ? 3 : 7;
    endfunction

    function automatic int sb_size(input int k);
        return (k == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic logic [DW-1:0] sb_front(input int k);
        return (k == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic sb_push(input int k, input logic [DW-1:0] v);
        if (k == 0) sb0.push_back(v);
        else        sb1.push_back(v);
    endtask

    task automatic sb_pop(input int k, output logic [DW-1:0] v);
        if (k == 0) v = sb0.pop_front();
        else        v = sb1.pop_front();
    endtask

    task automatic sb_clear(input int k);
        if (k == 0) sb0.delete();
        else        sb1.delete();
    endtask

    // Reference model: counts held payloads and records accepted data in order.
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_occ[k] = 0; m_stall[k] = 0; m_last[k] = '0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                bit fi;
                bit fo;
                fi = (in_valid == 1'b1) && m_ready(k);
                fo = (m_occ[k] > 0) && (out_ready == 1'b1);
                if (rst) begin
                    m_occ[k] = 0; m_stall[k] = 0; m_last[k] = '0;
                    sb_clear(k);
                end else begin
                    if (clr_cnt) m_stall[k] = 0;
                    else if (m_occ[k] > 0 && !out_ready && m_stall[k] < m_smax(k)) m_stall[k]++;
                    if (flush) begin
                        m_occ[k] = 0; m_last[k] = '0;
                        sb_clear(k);
                    end else begin
                        if (fi) sb_push(k, in_data);
                        m_occ[k] = m_occ[k] + int'(fi) - int'(fo);
                    end
                end
            end
        end
    end

    // Monitor: compares outputs mid-cycle, pops the scoreboard on each transfer.
    initial begin
        logic [DW-1:0] v;
        logic [63:0]   sv;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    sv = (k == 0) ? 64'(stall0) : 64'(stall1);
                    chk($sformatf("i%0d_out_valid", k), 64'(out_valid[k]), 64'(m_occ[k] > 0));
                    chk($sformatf("i%0d_occupancy", k), 64'(occupancy[k]), 64'(m_occ[k]));
                    chk($sformatf("i%0d_in_ready", k), 64'(in_ready[k]), 64'(m_ready(k)));
                    chk($sformatf("i%0d_stall_cnt", k), sv, 64'(m_stall[k]));
                    if (out_valid[k] === 1'b1) begin
                        if (sb_size(k) > 0) begin
                            chk($sformatf("i%0d_out_data", k), 64'(out_data[k]), 64'(sb_front(k)));
                            if (out_ready && !flush && !rst) begin
                                sb_pop(k, v);
                                m_last[k] = v;
                            end
                        end else begin
                            chk($sformatf("i%0d_spurious_valid", k), 64'(out_valid[k]), 64'd0);
                        end
                    end else begin
                        chk($sformatf("i%0d_idle_data", k), 64'(out_data[k]), 64'(m_last[k]));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] seq;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        clr_cnt = 1'b0; in_data = '0;
        step();
        chk_en = 1;
        step();
        rst = 1'b0;

        // streaming with a free downstream
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();

        // back-pressure: 0xA, 0xB held, stall counter saturates, then clear
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h000A; step();
        in_data = 16'h000B; step();
        in_valid = 1'b0;
        repeat (4) step();
        clr_cnt = 1'b1; step();
        clr_cnt = 1'b0; repeat (2) step();
        out_ready = 1'b1;
        repeat (3) step();

        // flush while full, with a payload offered in the flush cycle
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0011; step();
        in_data = 16'h0012; step();
        flush = 1'b1; in_data = 16'h000C; step();
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) step();

        // reset while full, then restart the stream
        in_valid = 1'b1; in_data = 16'h0021; step();
        in_data = 16'h0022; step();
        rst = 1'b1; in_data = 16'h0023; step();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(16'h0030 + i);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();

        // SKID_EN=0 toggle pattern: out_ready 1,0,1,0 with in_valid held
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            in_data = DW'(16'h0040 + i);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) step();

        // randomized traffic with occasional flush, clear and reset
        seq = 16'h0100;
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            clr_cnt   = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 249) == 0);
            in_data   = seq;
            seq       = seq + 16'd1;
            step();
        end

        // drain
        rst = 1'b0; flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        #1;
        chk("i0_leftover", 64'(sb0.size()), 64'd0);
        chk("i1_leftover", 64'(sb1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64: payload width in bits, legal range 1..1024.
REQ-002 Parameter SKID_EN, default 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.
REQ-003 Parameter CNT_W, default 16: stall counter width, legal range 1..32.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage accepts a payload this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  downstream payload valid.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  DATA_W  downstream payload.
REQ-013 occupancy  output  2  count of valid entries held, range 0..2.
REQ-014 clr_cnt  input  1  synchronous clear of stall_cnt.
REQ-015 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-016 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; a payload transfers only on a fire.
REQ-017 out_valid and out_data come directly from the main entry register; there is no combinational path from in_data to out_data.
REQ-018 SKID_EN=1: in_ready is a registered output equal to NOT skid_valid; there is no combinational path from out_ready to in_ready.
REQ-019 SKID_EN=1 states and transitions:
- EMPTY: main empty; in_fire -> ONE, main <= in_data.
- ONE: main valid, skid empty.
  - in_fire & out_fire -> ONE, main <= in_data.
  - in_fire & !out_fire -> FULL, skid <= in_data.
  - !in_fire & out_fire -> EMPTY.
  - neither -> hold.
- FULL: both entries valid, in_ready=0.
  - out_fire -> ONE, main <= skid.
  - otherwise -> hold.
REQ-020 SKID_EN=0: in_ready = !out_valid | out_ready (combinational).
- in_fire -> main <= in_data, valid=1.
- out_fire without in_fire -> valid=0.
- Otherwise hold.
REQ-021 Ordering is strict FIFO; no payload is dropped, duplicated or reordered except by flush or rst.
REQ-022 Priority order: rst > flush > normal operation.
REQ-023 Flush (rst=0, flush=1), effects on the next edge:
- All valid bits clear; main and skid data clear to 0; occupancy=0.
- Any in_fire in the flush cycle is discarded.
- in_ready returns to 1 on the next cycle.
REQ-024 In the flush cycle itself, out_valid still reflects the pre-flush state; downstream treats the out_fire as killed by the same flush.
REQ-025 occupancy equals main_valid + skid_valid and is registered.
REQ-026 stall_cnt update rule:
- Increments by 1 on each cycle with out_valid & !out_ready.
- Saturates at 2^CNT_W-1; no wrap.
- clr_cnt has priority over increment.
- flush does not affect stall_cnt.
REQ-027 When out_valid=0, out_data holds its last value; it is 0 only after rst or flush.

Reset
REQ-028 While rst=1, on each rising edge:
- out_valid=0, out_data=0, occupancy=0, stall_cnt=0.
- Skid entry cleared.
- in_ready=1 from the cycle after rst deasserts (SKID_EN=1); in_ready=1 immediately (SKID_EN=0).
REQ-029 rst asserted mid-operation discards all held payloads with no partial transfer; all inputs are ignored while rst=1.

Verification
REQ-030 Streaming, SKID_EN=1: in_valid=1 with data 1,2,3,... and out_ready=1 always -> out_data 1,2,3 one per cycle, first at cycle+1, in_ready stays 1.
REQ-031 Back-pressure, SKID_EN=1: send 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0. Then raise out_ready -> 0xA then 0xB on consecutive cycles, occupancy 2->1->0.
REQ-032 Flush: with occupancy=2 and flush=1 plus in_valid=1, data 0xC -> next cycle occupancy=0, out_valid=0, out_data=0, and 0xC never appears.
REQ-033 SKID_EN=0, out_ready toggling 1,0,1,0 with in_valid=1 -> in_ready follows !out_valid|out_ready each cycle; output order is preserved.
REQ-034 stall_cnt with CNT_W=2: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3. Pulse clr_cnt -> 0 on the next cycle, even if the stall continues.
REQ-035 Mid-stream rst: occupancy=2, assert rst for 1 cycle -> all outputs at reset values next cycle; the data stream restarts cleanly afterwards.
